// File: rtl/hdmux4_pkg.sv
// hdmux4_pkg: definitions shared by the HDMUX4 select sequencers.
//   LANES    : number of mux inputs (A0..A3)
//   SEL_W    : width of the mux select {SL1,SL0}
//   state_t  : sequencer FSM state
//   onehot4  : select index -> one-hot lane grant
package hdmux4_pkg;

  localparam int LANES = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [LANES-1:0] onehot4(input logic [SEL_W-1:0] sel);
    onehot4 = 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational round-robin picker for four requesters.
//   req : per-lane request vector
//   ptr : highest-priority lane; the scan runs ptr, ptr+1, ptr+2, ptr+3 (mod 4)
//   any : at least one lane is requesting
//   idx : first requesting lane in scan order (holds ptr when any=0)
module rr_pick4
  import hdmux4_pkg::*;
(
  input  logic [LANES-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] lane;

  always_comb begin
    any  = 1'b0;
    idx  = ptr;
    lane = ptr;
    for (int k = 0; k < LANES; k++) begin
      // 2-bit addition wraps naturally, giving the mod-4 scan order
      lane = ptr + SEL_W'(k);
      if (!any && req[lane]) begin
        any = 1'b1;
        idx = lane;
      end
    end
  end

endmodule

// File: rtl/hdmux4_rr_sel.sv
// hdmux4_rr_sel: round-robin select sequencer driving SL0/SL1 of an HDMUX4D4.
//   CK, RST   : clock (rising edge) and synchronous active-high reset
//   REQ[3:0]  : lane i holds REQ[i] while it has data on mux input Ai
//   RDY       : downstream consumer ready for mux output Z
//   SL0, SL1  : registered mux select, frozen for the whole grant
//   GNT[3:0]  : registered one-hot grant, zero when idle
//   ACK[3:0]  : beat accepted on lane i this cycle
//   VLD       : mux output Z carries valid data
//   dbg_state, dbg_ptr, dbg_beats : FSM state, priority pointer, beat count
//
// Handshake: a beat transfers on every cycle where VLD and RDY are both high.
// VLD is the granted lane's REQ and never depends on RDY; RDY may be low for
// any number of cycles and the grant simply waits. ACK[i] flags the transfer
// back to the granted lane.
module hdmux4_rr_sel
  import hdmux4_pkg::*;
#(
  parameter int BURST_MAX = 4,  // beats per grant before rotation, 0 = unlimited
  parameter int CNT_W     = 8   // beat counter width, 2**CNT_W > BURST_MAX
) (
  input  logic             CK,
  input  logic             RST,
  input  logic [LANES-1:0] REQ,
  input  logic             RDY,
  output logic             SL0,
  output logic             SL1,
  output logic [LANES-1:0] GNT,
  output logic [LANES-1:0] ACK,
  output logic             VLD,
  output state_t           dbg_state,
  output logic [SEL_W-1:0] dbg_ptr,
  output logic [CNT_W-1:0] dbg_beats
);

  localparam logic             LIMITED   = (BURST_MAX != 0);
  localparam logic [CNT_W-1:0] LAST_BEAT = (BURST_MAX == 0) ? '0 : CNT_W'(BURST_MAX - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic [LANES-1:0] gnt_q, gnt_d;

  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic             granted_req;
  logic             vld;
  logic             xfer;

  rr_pick4 u_pick (
    .req (REQ),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign granted_req = REQ[sel_q];
  assign vld         = (state_q == GRANT) && granted_req;
  assign xfer        = vld && RDY;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    beats_d = beats_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        // SEL keeps its last value while nobody requests
        if (pick_any) begin
          state_d = GRANT;
          sel_d   = pick_idx;
          gnt_d   = onehot4(pick_idx);
          beats_d = '0;
        end
      end
      GRANT: begin
        // A dropped request and a final beat in the same cycle collapse
        // into one release; both leave the same next state.
        if (!granted_req || (xfer && LIMITED && (beats_q == LAST_BEAT))) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = sel_q + SEL_W'(1);
          beats_d = '0;
        end else if (xfer && (beats_q != '1)) begin
          // saturation only matters in unlimited mode
          beats_d = beats_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      beats_q <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      beats_q <= beats_d;
      gnt_q   <= gnt_d;
    end
  end

  assign SL0       = sel_q[0];
  assign SL1       = sel_q[1];
  assign GNT       = gnt_q;
  assign VLD       = vld;
  assign ACK       = gnt_q & REQ & {LANES{RDY}};
  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;
  assign dbg_beats = beats_q;

endmodule

// File: tb/tb_hdmux4_rr_sel.sv
// tb_hdmux4_rr_sel: three sequencers (burst limits 4, 2 and unlimited) share
// one stimulus stream; every output is compared each cycle against a
// behavioural model, with directed scenarios adding literal expectations.
module tb_hdmux4_rr_sel;
  import hdmux4_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] req;
  logic       rdy;

  logic       sl0_o[3];
  logic       sl1_o[3];
  logic [3:0] gnt_o[3];
  logic [3:0] ack_o[3];
  logic       vld_o[3];
  state_t     st_o[3];
  logic [1:0] ptr_o[3];
  logic [7:0] beats_o[3];

  hdmux4_rr_sel #(.BURST_MAX(4), .CNT_W(8)) u_dut_b4 (
    .CK(clk), .RST(rst), .REQ(req), .RDY(rdy),
    .SL0(sl0_o[0]), .SL1(sl1_o[0]), .GNT(gnt_o[0]), .ACK(ack_o[0]), .VLD(vld_o[0]),
    .dbg_state(st_o[0]), .dbg_ptr(ptr_o[0]), .dbg_beats(beats_o[0])
  );

  hdmux4_rr_sel #(.BURST_MAX(2), .CNT_W(8)) u_dut_b2 (
    .CK(clk), .RST(rst), .REQ(req), .RDY(rdy),
    .SL0(sl0_o[1]), .SL1(sl1_o[1]), .GNT(gnt_o[1]), .ACK(ack_o[1]), .VLD(vld_o[1]),
    .dbg_state(st_o[1]), .dbg_ptr(ptr_o[1]), .dbg_beats(beats_o[1])
  );

  hdmux4_rr_sel #(.BURST_MAX(0), .CNT_W(8)) u_dut_b0 (
    .CK(clk), .RST(rst), .REQ(req), .RDY(rdy),
    .SL0(sl0_o[2]), .SL1(sl1_o[2]), .GNT(gnt_o[2]), .ACK(ack_o[2]), .VLD(vld_o[2]),
    .dbg_state(st_o[2]), .dbg_ptr(ptr_o[2]), .dbg_beats(beats_o[2])
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per instance: is a lane owning the mux, which lane the select points at,
  // which lane has top priority next, and how many beats this grant has moved.
  int bmax[3] = '{4, 2, 0};
  bit m_busy[3];
  int m_sel[3];
  int m_ptr[3];
  int m_cnt[3];
  bit started = 1'b0;

  task automatic model_release(input int k);
    m_busy[k] = 1'b0;
    m_ptr[k]  = (m_sel[k] + 1) % 4;
    m_cnt[k]  = 0;
  endtask

  always @(posedge clk) begin
    started = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_busy[k] = 1'b0;
        m_sel[k]  = 0;
        m_ptr[k]  = 0;
        m_cnt[k]  = 0;
      end else if (!m_busy[k]) begin
        int best;
        int bestd;
        best  = -1;
        bestd = 99;
        // winner: the requester closest to the pointer going upward
        for (int i = 0; i < 4; i++) begin
          if (req[i] && (((i - m_ptr[k] + 4) % 4) < bestd)) begin
            best  = i;
            bestd = (i - m_ptr[k] + 4) % 4;
          end
        end
        if (best >= 0) begin
          m_busy[k] = 1'b1;
          m_sel[k]  = best;
          m_cnt[k]  = 0;
        end
      end else if (!req[m_sel[k]]) begin
        model_release(k);
      end else if (rdy) begin
        m_cnt[k] = (m_cnt[k] < 255) ? m_cnt[k] + 1 : 255;
        if (bmax[k] != 0 && m_cnt[k] == bmax[k]) model_release(k);
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        logic [3:0] eg;
        logic       ev;
        logic [3:0] ea;
        eg = m_busy[k] ? (4'b0001 << m_sel[k]) : 4'b0000;
        ev = m_busy[k] && req[m_sel[k]];
        ea = (ev && rdy) ? eg : 4'b0000;
        chk($sformatf("d%0d_gnt", k), gnt_o[k], eg);
        chk($sformatf("d%0d_ack", k), ack_o[k], ea);
        chk($sformatf("d%0d_vld", k), vld_o[k], ev);
        chk($sformatf("d%0d_sl", k), {sl1_o[k], sl0_o[k]}, m_sel[k]);
        chk($sformatf("d%0d_ptr", k), ptr_o[k], m_ptr[k]);
        chk($sformatf("d%0d_beats", k), beats_o[k], m_cnt[k]);
        chk($sformatf("d%0d_state", k), st_o[k], m_busy[k] ? GRANT : IDLE);
      end
    end
  end

  // ---------------- grant-order scoreboard (burst limit 2 instance) ----------------
  logic [1:0] exp_q[$];
  bit         mon_en = 1'b0;
  logic [3:0] prev_gnt1 = 4'b0000;
  int         ack_cnt1 = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (gnt_o[1] != 4'b0000 && prev_gnt1 == 4'b0000) begin
        ack_cnt1 = 0;
        if (exp_q.size() == 0) begin
          chk("t2_extra_grant", gnt_o[1], 4'b0000);
        end else begin
          logic [1:0] lane;
          lane = exp_q.pop_front();
          chk("t2_order_sl", {sl1_o[1], sl0_o[1]}, lane);
        end
      end
      if (gnt_o[1] != 4'b0000 && ack_o[1] != 4'b0000) ack_cnt1++;
      if (gnt_o[1] == 4'b0000 && prev_gnt1 != 4'b0000) chk("t2_acks_per_grant", ack_cnt1, 2);
    end
    prev_gnt1 = gnt_o[1];
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // leaves rst low just after an edge; caller then drives req/rdy
  task automatic do_reset();
    step();
    rst = 1'b1;
    req = 4'b0000;
    rdy = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int acks;
    int cyc;
    logic [7:0] prevb;

    rst = 1'b1;
    req = 4'b0000;
    rdy = 1'b0;

    // single requester, burst of 4, bubble, re-grant
    do_reset();
    req = 4'b0010;
    rdy = 1'b1;
    @(negedge clk);
    chk("t1_reset_gnt", gnt_o[0], 4'b0000);
    chk("t1_reset_sl", {sl1_o[0], sl0_o[0]}, 2'b00);
    chk("t1_reset_vld", vld_o[0], 1'b0);
    chk("t1_reset_ptr", ptr_o[0], 2'd0);
    @(negedge clk);
    chk("t1_gnt", gnt_o[0], 4'b0010);
    chk("t1_sl", {sl1_o[0], sl0_o[0]}, 2'b01);
    acks = 0;
    cyc  = 0;
    while (gnt_o[0] != 4'b0000 && cyc < 20) begin
      if (ack_o[0][1]) acks++;
      @(negedge clk);
      cyc++;
    end
    chk("t1_acks", acks, 4);
    chk("t1_bubble", gnt_o[0], 4'b0000);
    chk("t1_ptr", ptr_o[0], 2'd2);
    @(negedge clk);
    chk("t1_regrant", gnt_o[0], 4'b0010);

    // all lanes requesting, burst limit 2: order 0,1,2,3,0
    do_reset();
    exp_q.delete();
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    mon_en = 1'b1;
    req = 4'b1111;
    rdy = 1'b1;
    repeat (16) @(negedge clk);
    mon_en = 1'b0;
    chk("t2_grants_left", exp_q.size(), 0);

    // lane 2 stalled by RDY=0 for 10 cycles
    do_reset();
    req = 4'b0100;
    rdy = 1'b0;
    @(negedge clk);
    repeat (10) begin
      @(negedge clk);
      chk("t3_sl", {sl1_o[0], sl0_o[0]}, 2'b10);
      chk("t3_gnt", gnt_o[0], 4'b0100);
      chk("t3_vld", vld_o[0], 1'b1);
      chk("t3_ack", ack_o[0], 4'b0000);
      chk("t3_beats", beats_o[0], 8'd0);
    end
    step();
    rdy = 1'b1;
    @(negedge clk);
    chk("t3_resume_ack", ack_o[0], 4'b0100);
    chk("t3_resume_beats0", beats_o[0], 8'd0);
    @(negedge clk);
    chk("t3_resume_beats1", beats_o[0], 8'd1);

    // lane 3 drops after one beat, lane 0 waiting
    do_reset();
    req = 4'b1000;
    rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_first_ack", ack_o[0], 4'b1000);
    step();
    req = 4'b0001;
    @(negedge clk);
    chk("t4_drop_ack", ack_o[0], 4'b0000);
    chk("t4_drop_vld", vld_o[0], 1'b0);
    chk("t4_drop_gnt", gnt_o[0], 4'b1000);
    chk("t4_drop_beats", beats_o[0], 8'd1);
    @(negedge clk);
    chk("t4_bubble", gnt_o[0], 4'b0000);
    chk("t4_ptr", ptr_o[0], 2'd0);
    @(negedge clk);
    chk("t4_lane0", gnt_o[0], 4'b0001);

    // reset in the middle of a lane-1 burst
    do_reset();
    req = 4'b0010;
    rdy = 1'b1;
    step();
    step();
    step();
    rst = 1'b1;
    req = 4'b1010;
    @(negedge clk);
    chk("t5_beats_before", beats_o[0], 8'd2);
    chk("t5_gnt_before", gnt_o[0], 4'b0010);
    @(negedge clk);
    chk("t5_sl", {sl1_o[0], sl0_o[0]}, 2'b00);
    chk("t5_gnt", gnt_o[0], 4'b0000);
    chk("t5_vld", vld_o[0], 1'b0);
    chk("t5_ptr", ptr_o[0], 2'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_first_grant", gnt_o[0], 4'b0010);

    // unlimited burst: counter saturates, grant never rotates
    do_reset();
    req = 4'b0001;
    rdy = 1'b1;
    @(negedge clk);
    prevb = 8'd0;
    repeat (300) begin
      @(negedge clk);
      chk("t6_gnt", gnt_o[2], 4'b0001);
      chk("t6_sl", {sl1_o[2], sl0_o[2]}, 2'b00);
      chk("t6_nowrap", beats_o[2] >= prevb, 1'b1);
      prevb = beats_o[2];
    end
    chk("t6_saturated", beats_o[2], 8'd255);

    // random traffic: lanes toggle occasionally, RDY mostly high, rare resets
    do_reset();
    req = 4'b0000;
    rdy = 1'b1;
    repeat (3000) begin
      step();
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
      end
      rdy = ($urandom_range(0, 3) != 0);
    end
    step();
    rst = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
